display_mux_n: RTL

Parametrised multiplexed seven-segment driver for the board's scoreboard and status digits. It accepts a binary value on a load strobe and converts it to BCD with a sequential shift-add-3 engine. The result is latched atomically and scanned across `NUM_DIGITS` common-anode digits at a programmable refresh rate. Adds overflow indication, a per-digit blank mask and optional leading-zero suppression; sits between the game core and the board pins.

---
 rtl/display_mux_n.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/display_mux_n.sv
// display_mux_n: binary-to-BCD converter (sequential shift-add-3) feeding a
// multiplexed common-anode seven-segment scanner with overflow dash, per-digit
// blank mask and optional leading-zero suppression.
// Optional feature macro: DISPLAY_LZB_EN (leading-zero blanking when defined).
module display_mux_n #(
    parameter int NUM_DIGITS  = 8,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      valor,
    input  logic                  cargar,
    input  logic [NUM_DIGITS-1:0] mascara,
    output logic                  ocupado,
    output logic                  desborde,
    output logic [6:0]            display,
    output logic [NUM_DIGITS-1:0] anodos
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] LAST_DIV  = DIV_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t state, state_next;

    logic load, step, finish;

    logic [BIN_W-1:0] bin_sr;
    logic [BCD_W-1:0] work_bcd;
    logic [BCD_W-1:0] adj_bcd;
    logic [BCD_W-1:0] shifted_bcd;
    logic             carry_out;
    logic             sticky;
    logic [CNT_W-1:0] step_cnt;
    logic [BCD_W-1:0] shown_bcd;

    logic [DIV_W-1:0] div_cnt;
    logic [IDX_W-1:0] idx;

    logic [3:0]            sel_code;
    logic                  sel_mask;
    logic [NUM_DIGITS-1:0] anodos_next;
    logic [6:0]            seg_next;

`ifdef DISPLAY_LZB_EN
    logic [NUM_DIGITS-1:0] lz_vec;
    logic                  lz_run;
    logic                  sel_lz;
`endif

    // Active-low segment pattern for a BCD code; non-decimal codes show a dash.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1011000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = SEG_DASH;
        endcase
    endfunction

    // Converter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Converter next state: loads only in IDLE, the last shift step returns to IDLE.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (cargar) begin
                    load       = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                step = 1'b1;
                if (step_cnt == LAST_STEP) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ocupado = (state == CONV);

    // One shift-add-3 step: adjust every digit >= 5, then shift in the binary MSB.
    always_comb begin
        adj_bcd = work_bcd;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (work_bcd[4*d +: 4] >= 4'd5) begin
                adj_bcd[4*d +: 4] = work_bcd[4*d +: 4] + 4'd3;
            end
        end
        shifted_bcd = {adj_bcd[BCD_W-2:0], bin_sr[BIN_W-1]};
        carry_out   = adj_bcd[BCD_W-1];
    end

    // Conversion datapath; the shown value and overflow flag are updated only by the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr    <= '0;
            work_bcd  <= '0;
            sticky    <= 1'b0;
            step_cnt  <= '0;
            shown_bcd <= '0;
            desborde  <= 1'b0;
        end else if (load) begin
            bin_sr   <= valor;
            work_bcd <= '0;
            sticky   <= 1'b0;
            step_cnt <= '0;
        end else if (step) begin
            bin_sr   <= bin_sr << 1;
            work_bcd <= shifted_bcd;
            sticky   <= sticky | carry_out;
            step_cnt <= step_cnt + CNT_W'(1);
            if (finish) begin
                shown_bcd <= shifted_bcd;
                desborde  <= sticky | carry_out;
            end
        end
    end

    // Refresh divider and digit index, free-running regardless of the converter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == LAST_DIV) begin
            div_cnt <= '0;
            idx     <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

`ifdef DISPLAY_LZB_EN
    // Leading-zero flags: digit i>0 is blank when it and all higher digits are zero.
    always_comb begin
        lz_vec = '0;
        lz_run = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            lz_run    = lz_run && (shown_bcd[4*d +: 4] == 4'd0);
            lz_vec[d] = lz_run && (d != 0);
        end
    end
`endif

    // Select the current digit's code, mask and anode, then resolve segment priority.
    always_comb begin
        sel_code    = 4'd0;
        sel_mask    = 1'b0;
        anodos_next = '1;
`ifdef DISPLAY_LZB_EN
        sel_lz      = 1'b0;
`endif
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx == IDX_W'(d)) begin
                sel_code       = shown_bcd[4*d +: 4];
                sel_mask       = mascara[d];
                anodos_next[d] = 1'b0;
`ifdef DISPLAY_LZB_EN
                sel_lz         = lz_vec[d];
`endif
            end
        end
        if (sel_mask) begin
            seg_next = SEG_OFF;
        end else if (desborde) begin
            seg_next = SEG_DASH;
`ifdef DISPLAY_LZB_EN
        end else if (sel_lz) begin
            seg_next = SEG_OFF;
`endif
        end else begin
            seg_next = glyph(sel_code);
        end
    end

    // Anodes and segments are registered together so they always describe the same digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display <= SEG_OFF;
            anodos  <= '1;
        end else begin
            display <= seg_next;
            anodos  <= anodos_next;
        end
    end

endmodule
